// File: rtl/ctrl_pkt_fifo_reader.sv
// ctrl_pkt_fifo_reader
// Read side of the controller-interactive packet FIFO (512x134, show-ahead).
// Counts complete packets from the write side's tail pulse, starts a packet
// only when one is whole and downstream is ready, streams it contiguously
// and then holds off for an inter-packet gap. Packets that do not begin with
// a head word are consumed and dropped.
// Optional feature macro: PKT_LEN_CHECK_EN -- truncates packets longer than
// MAX_PKT_WORDS (last kept word re-tagged as tail) and adds o_len_err.
// Word tags in [133:132]: 01 head, 11 middle, 10 tail.

module ctrl_pkt_fifo_reader #(
    parameter int IFG_CYCLES    = 2,
    parameter int MAX_PKT_WORDS = 128
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_pkt_tail_wr,
    input  logic [133:0] iv_fifo_rdata,
    input  logic         i_fifo_empty,
    output logic         o_fifo_rd,
    input  logic         i_tx_ready,
    output logic [133:0] ov_data,
    output logic         o_data_wr,
    output logic [8:0]   ov_pending_pkts,
    output logic         o_fmt_err
`ifdef PKT_LEN_CHECK_EN
    ,
    output logic         o_len_err
`endif
);

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_TAIL = 2'b10;
    localparam logic [8:0] PEND_MAX = 9'd511;
    // GAP_S holds reads off for IFG_CYCLES+1 cycles, so the next head reaches
    // ov_data IFG_CYCLES+2 cycles after the previous tail did.
    localparam logic [7:0] GAP_LAST = 8'(IFG_CYCLES);

    // Reject parameter values the 8-bit counters cannot represent.
    if (IFG_CYCLES < 0 || IFG_CYCLES > 255 ||
        MAX_PKT_WORDS < 2 || MAX_PKT_WORDS > 256) begin : g_bad_params
        $error("ctrl_pkt_fifo_reader: IFG_CYCLES or MAX_PKT_WORDS out of range");
    end

    typedef enum logic [1:0] {
        IDLE_S,
        READ_S,
        DISCARD_S,
        GAP_S
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [7:0]   r_gap_cnt;
    logic [7:0]   w_gap_cnt_nxt;
    logic [8:0]   r_pending;
    logic [133:0] r_data;
    logic         r_data_wr;
    logic         r_fmt_err;

    logic [1:0]   w_tag;
    logic         w_start;
    logic         w_tail_rd;
    logic         w_fwd;
    logic [133:0] w_fwd_data;
    logic         w_fmt_err;

`ifdef PKT_LEN_CHECK_EN
    localparam logic [7:0] LEN_LAST = 8'(MAX_PKT_WORDS - 1);
    logic [7:0]   r_word_cnt;
    logic [7:0]   w_word_cnt_nxt;
    logic         r_len_err;
    logic         w_len_err;
`endif

    assign w_tag   = iv_fifo_rdata[133:132];
    assign w_start = (r_pending != 9'd0) && i_tx_ready && !i_fifo_empty;

    assign o_fifo_rd = ((r_state == IDLE_S) && w_start) ||
                       (((r_state == READ_S) || (r_state == DISCARD_S)) && !i_fifo_empty);

    // A tail leaves the FIFO whenever a word tagged 10 is acknowledged,
    // whether it is forwarded or dropped.
    assign w_tail_rd = o_fifo_rd && (w_tag == TAG_TAIL);

    // Next-state and per-cycle forwarding decision.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        w_state_nxt   = r_state;
        w_gap_cnt_nxt = r_gap_cnt;
        w_fwd         = 1'b0;
        w_fwd_data    = iv_fifo_rdata;
        w_fmt_err     = 1'b0;
`ifdef PKT_LEN_CHECK_EN
        w_word_cnt_nxt = r_word_cnt;
        w_len_err      = 1'b0;
`endif
        case (r_state)
            IDLE_S: begin
                if (w_start) begin
                    if (w_tag == TAG_HEAD) begin
                        w_fwd       = 1'b1;
                        w_state_nxt = READ_S;
`ifdef PKT_LEN_CHECK_EN
                        w_word_cnt_nxt = 8'd1;
`endif
                    end else begin
                        // Malformed start: drop it; a lone tail closes the packet at once.
                        w_fmt_err   = 1'b1;
                        w_state_nxt = (w_tag == TAG_TAIL) ? IDLE_S : DISCARD_S;
                    end
                end
            end
            READ_S: begin
                // An empty FIFO mid-packet just produces an output bubble.
                if (!i_fifo_empty) begin
                    w_fwd = 1'b1;
`ifdef PKT_LEN_CHECK_EN
                    w_word_cnt_nxt = 8'(r_word_cnt + 8'd1);
`endif
                    if (w_tag == TAG_TAIL) begin
                        w_gap_cnt_nxt = 8'd0;
                        w_state_nxt   = (IFG_CYCLES > 0) ? GAP_S : IDLE_S;
                    end
`ifdef PKT_LEN_CHECK_EN
                    else if (r_word_cnt == LEN_LAST) begin
                        // Over-long packet: close it here, drop the rest.
                        w_fwd_data[133:132] = TAG_TAIL;
                        w_len_err           = 1'b1;
                        w_state_nxt         = DISCARD_S;
                    end
`endif
                end
            end
            DISCARD_S: begin
                if (!i_fifo_empty && (w_tag == TAG_TAIL)) begin
                    w_state_nxt = IDLE_S;
                end
            end
            GAP_S: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE_S;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE_S;
            end
        endcase
    end

    // State register and gap/word counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!i_rst_n) begin
            r_state   <= IDLE_S;
            r_gap_cnt <= 8'd0;
`ifdef PKT_LEN_CHECK_EN
            r_word_cnt <= 8'd0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
`ifdef PKT_LEN_CHECK_EN
            r_word_cnt <= w_word_cnt_nxt;
`endif
        end
    end

    // Complete-packet counter: saturating up on tail written, down on tail read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= 9'd0;
        end else if (i_pkt_tail_wr && !w_tail_rd) begin
            if (r_pending != PEND_MAX) begin
                r_pending <= r_pending + 9'd1;
            end
        end else if (w_tail_rd && !i_pkt_tail_wr) begin
            if (r_pending != 9'd0) begin
                r_pending <= r_pending - 9'd1;
            end
        end
    end

    // Registered output stage: one cycle after the FIFO read, zero when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data    <= '0;
            r_data_wr <= 1'b0;
            r_fmt_err <= 1'b0;
`ifdef PKT_LEN_CHECK_EN
            r_len_err <= 1'b0;
`endif
        end else begin
            r_data    <= w_fwd ? w_fwd_data : '0;
            r_data_wr <= w_fwd;
            r_fmt_err <= w_fmt_err;
`ifdef PKT_LEN_CHECK_EN
            r_len_err <= w_len_err;
`endif
        end
    end

    assign ov_data         = r_data;
    assign o_data_wr       = r_data_wr;
    assign ov_pending_pkts = r_pending;
    assign o_fmt_err       = r_fmt_err;
`ifdef PKT_LEN_CHECK_EN
    assign o_len_err       = r_len_err;
`endif

endmodule
